mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single slow-memory port between the instruction cache (read-only refills) and the data cache (write-back plus read-allocate).
- Sits between both caches' memory interfaces and the top-level memory.
- Round-robin arbitration, one transaction at a time.
- Memory outputs are registered and held stable until mem_ready.

Parameters:
ADDR_W, 28, block address width (word address bits minus 2-bit word offset)
DATA_W, 128, cache line width in bits (4 x 32-bit words)
DC_FIRST, 1, winner of the first simultaneous request after reset (1 = D-cache, 0 = I-cache)

Ports:
clk  in  1  system clock, rising edge
proc_reset_n  in  1  asynchronous, active-low reset
ic_mem_read  in  1  I-cache refill request, held until ic_mem_ready
ic_mem_addr  in  ADDR_W  I-cache block address
ic_mem_rdata  out  DATA_W  refill line to I-cache
ic_mem_ready  out  1  I-cache transaction complete, 1-cycle pulse
dc_mem_read  in  1  D-cache read request, held until dc_mem_ready
dc_mem_write  in  1  D-cache write-back request, held until dc_mem_ready
dc_mem_addr  in  ADDR_W  D-cache block address
dc_mem_wdata  in  DATA_W  D-cache write-back line
dc_mem_rdata  out  DATA_W  refill line to D-cache
dc_mem_ready  out  1  D-cache transaction complete, 1-cycle pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory block address
mem_wdata  out  DATA_W  memory write line
mem_rdata  in  DATA_W  memory read line
mem_ready  in  1  memory done, 1-cycle pulse
arb_busy  out  1  high while a memory transaction is outstanding
arb_err  out  1  sticky; set when dc_mem_read and dc_mem_write are both high in S_IDLE

Behaviour:
- Reset (proc_reset_n low, asynchronous):
  - state = S_IDLE.
  - mem_read, mem_write, arb_err = 0; mem_addr, mem_wdata = 0.
  - last-served pointer = I-cache if DC_FIRST = 1, else D-cache. This makes the first tie go to the selected cache.
  - Reset asserted mid-transaction abandons the transaction. No ready pulse is issued; memory is assumed reset together with the arbiter.
- States: S_IDLE, S_GRANT_I, S_GRANT_D.
- S_IDLE:
  - Sample requests.
    - ic_req = ic_mem_read.
    - dc_req = dc_mem_read | dc_mem_write.
  - Neither request: stay in S_IDLE.
  - One request: grant it.
  - Both requests: grant the requester not equal to the last-served pointer.
  - On grant, at the same edge:
    - register mem_read / mem_write and mem_addr;
    - register mem_wdata (D write only, else 0);
    - update the pointer;
    - move to S_GRANT_x.
  - arb_busy = 1 from the cycle after the grant edge.
- D-cache read and write both high in S_IDLE: treat as a write, set arb_err (sticky until reset).
- S_GRANT_I / S_GRANT_D:
  - Hold all mem_* outputs constant; input changes are ignored.
  - When mem_ready = 1:
    - assert the winner's *_mem_ready combinationally in the same cycle;
    - the winner's *_rdata = mem_rdata in that cycle.
  - At the next edge:
    - clear mem_read / mem_write, mem_addr, mem_wdata to 0;
    - state returns to S_IDLE, arb_busy = 0.
- Latency:
  - Request sampled at edge E gives mem strobe visible from E+.
  - Minimum one S_IDLE cycle between consecutive transactions (bubble), so back-to-back grants are 1 cycle apart after the ready cycle.
- ic_mem_rdata and dc_mem_rdata are driven with mem_rdata when their ready is high, else 0.
- The loser's request is not lost. It stays asserted by its cache and is served on the next S_IDLE evaluation. Strict alternation under saturation bounds the wait to one transaction.
- A requester deasserting while granted (illegal): the transaction still completes on memory and the ready pulse is still issued; no error is flagged.
- A D-cache write-back followed by a read-allocate of the same line is two separate grants. The I-cache may be served between them.
- mem_ready observed in S_IDLE (spurious): ignored, no ready pulse.

Decomposition:
- Shared package holds:
  - state encoding constants (S_IDLE = 0, S_GRANT_I = 1, S_GRANT_D = 2);
  - requester ID constants (REQ_I = 0, REQ_D = 1);
  - ADDR_W / DATA_W defaults shared with both caches.
- One natural sub-module: rr_arbiter2. It is a 2-input round-robin pick, combinational, taking the pointer input and returning a grant one-hot. The pointer register stays in mem_arbiter.

Test Plan:
- Reset then single I request: ic_mem_read=1, ic_mem_addr=28'h0000123 → next cycle mem_read=1, mem_addr=28'h0000123. Memory returns 128'hA5…A5 with mem_ready after 5 cycles → ic_mem_ready=1 and ic_mem_rdata=128'hA5…A5 in that cycle; mem_read=0 the next cycle.
- Simultaneous first requests, DC_FIRST=1: D write to 28'h10 and I read to 28'h20 → D granted first (mem_write=1, mem_addr=28'h10, mem_wdata = D line). After dc_mem_ready and one S_IDLE cycle, mem_read=1, mem_addr=28'h20.
- Saturation: both caches request continuously for 6 transactions → grant order D,I,D,I,D,I; ic_mem_ready and dc_mem_ready never pulse in the same cycle.
- Stability: change dc_mem_addr/dc_mem_wdata while S_GRANT_D → mem_addr/mem_wdata unchanged until mem_ready.
- Error/corner: dc_mem_read=dc_mem_write=1 in S_IDLE → write issued, arb_err=1 and stays 1. Spurious mem_ready in S_IDLE → no ready pulse.
- Reset mid-transaction: proc_reset_n low while S_GRANT_I → mem_read=0 immediately (asynchronous), no ic_mem_ready. After release, a pending request is re-granted from S_IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory-port arbiter
package mem_arbiter_pkg;

  // Default widths shared with both cache memory interfaces
  localparam int ARB_ADDR_W = 28;
  localparam int ARB_DATA_W = 128;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2
  } arb_state_t;

  // Requester IDs, also used as bit positions in request/grant vectors
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Pack the two request lines into a vector indexed by requester ID
  function automatic logic [1:0] req_vec(input logic ic_req, input logic dc_req);
    return {dc_req, ic_req};
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rtl/mem_arbiter_rr_arbiter2.sv - combinational two-input round-robin pick
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone request wins outright; on a tie the requester not served last wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == REQ_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one slow memory port between I-cache and D-cache
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter bit DC_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy,
  output logic              arb_err
);

  arb_state_t state;
  logic       last_ptr;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       dc_both;

  assign req     = req_vec(ic_mem_read, dc_mem_read | dc_mem_write);
  assign dc_both = dc_mem_read & dc_mem_write;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last_ptr),
    .gnt  (gnt)
  );

  // Grant, hold the registered memory request, and release it after mem_ready
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state     <= S_IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_ptr  <= DC_FIRST ? REQ_I : REQ_D;
      arb_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Read and write together is treated as a write-back and flagged
          if (dc_both) begin
            arb_err <= 1'b1;
          end
          if (gnt[REQ_D]) begin
            state     <= S_GRANT_D;
            mem_read  <= dc_mem_read & ~dc_mem_write;
            mem_write <= dc_mem_write;
            mem_addr  <= dc_mem_addr;
            mem_wdata <= dc_mem_write ? dc_mem_wdata : '0;
            last_ptr  <= REQ_D;
          end else if (gnt[REQ_I]) begin
            state     <= S_GRANT_I;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= ic_mem_addr;
            mem_wdata <= '0;
            last_ptr  <= REQ_I;
          end
        end
        S_GRANT_I, S_GRANT_D: begin
          if (mem_ready) begin
            state     <= S_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Completion is forwarded to the winner in the same cycle memory reports it
  always_comb begin
    ic_mem_ready = (state == S_GRANT_I) && mem_ready;
    dc_mem_ready = (state == S_GRANT_D) && mem_ready;
    ic_mem_rdata = ic_mem_ready ? mem_rdata : '0;
    dc_mem_rdata = dc_mem_ready ? mem_rdata : '0;
    arb_busy     = (state != S_IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         ic_mem_read;
  logic [27:0]  ic_mem_addr;
  logic [127:0] ic_mem_rdata;
  logic         ic_mem_ready;
  logic         dc_mem_read;
  logic         dc_mem_write;
  logic [27:0]  dc_mem_addr;
  logic [127:0] dc_mem_wdata;
  logic [127:0] dc_mem_rdata;
  logic         dc_mem_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         arb_busy;
  logic         arb_err;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .DC_FIRST(1'b1)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_mem_ready (ic_mem_ready),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_rdata (dc_mem_rdata),
    .dc_mem_ready (dc_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .arb_busy     (arb_busy),
    .arb_err      (arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         ic_rd;
    logic         dc_rd;
    logic         dc_wr;
    logic [27:0]  ic_addr;
    logic [27:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic [127:0] rdata;
    int           lat;
    logic         exp_rd;
    logic         exp_wr;
    logic [27:0]  exp_addr;
    logic [127:0] exp_wdata;
    logic         exp_d;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    ic_mem_read  = 1'b0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
  endtask

  task automatic reset_dut();
    proc_reset_n = 1'b0;
    drop_reqs();
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    proc_reset_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic exp_d;

    ic_mem_addr  = '0;
    dc_mem_addr  = '0;
    dc_mem_wdata = '0;
    reset_dut();

    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_err", arb_err, 0);

    vecs[0] = '{"i_read_a5", 1, 0, 0, 28'h0000123, 28'h0, 128'h0,
                {16{8'hA5}}, 5, 1, 0, 28'h0000123, 128'h0, 0, 0};
    vecs[1] = '{"d_read", 0, 1, 0, 28'h0, 28'h0ABCDEF, 128'hDEAD_BEEF,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 2, 1, 0, 28'h0ABCDEF, 128'h0, 1, 0};
    vecs[2] = '{"d_write", 0, 0, 1, 28'h0, 28'h0000010, {4{32'h1111_2222}},
                128'hFF, 3, 0, 1, 28'h0000010, {4{32'h1111_2222}}, 1, 0};
    vecs[3] = '{"i_read_max", 1, 0, 0, 28'hFFFFFFF, 28'h0, 128'h0,
                {4{32'hCAFE_F00D}}, 1, 1, 0, 28'hFFFFFFF, 128'h0, 0, 0};
    vecs[4] = '{"d_rd_wr_err", 0, 1, 1, 28'h0, 28'h0000005, {16{8'h5A}},
                128'h77, 2, 0, 1, 28'h0000005, {16{8'h5A}}, 1, 1};
    vecs[5] = '{"i_err_sticky", 1, 0, 0, 28'h0000777, 28'h0, 128'h0,
                128'h1234, 1, 1, 0, 28'h0000777, 128'h0, 0, 1};

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      ic_mem_read  = v.ic_rd;
      ic_mem_addr  = v.ic_addr;
      dc_mem_read  = v.dc_rd;
      dc_mem_write = v.dc_wr;
      dc_mem_addr  = v.dc_addr;
      dc_mem_wdata = v.dc_wdata;
      tick();
      chk({v.name, "_mem_read"}, mem_read, v.exp_rd);
      chk({v.name, "_mem_write"}, mem_write, v.exp_wr);
      chk({v.name, "_mem_addr"}, mem_addr, v.exp_addr);
      chk({v.name, "_mem_wdata"}, mem_wdata, v.exp_wdata);
      chk({v.name, "_busy"}, arb_busy, 1);
      chk({v.name, "_err"}, arb_err, v.exp_err);
      repeat (v.lat - 1) tick();
      mem_rdata = v.rdata;
      mem_ready = 1'b1;
      #1;
      chk({v.name, "_ic_ready"}, ic_mem_ready, !v.exp_d);
      chk({v.name, "_dc_ready"}, dc_mem_ready, v.exp_d);
      chk({v.name, "_ic_rdata"}, ic_mem_rdata, v.exp_d ? 128'h0 : v.rdata);
      chk({v.name, "_dc_rdata"}, dc_mem_rdata, v.exp_d ? v.rdata : 128'h0);
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      drop_reqs();
      chk({v.name, "_done_read"}, mem_read, 0);
      chk({v.name, "_done_write"}, mem_write, 0);
      chk({v.name, "_done_addr"}, mem_addr, 0);
      chk({v.name, "_done_busy"}, arb_busy, 0);
    end

    // Simultaneous first requests after reset: D-cache wins, then I-cache after a bubble
    reset_dut();
    chk("reset_clears_err", arb_err, 0);
    dc_mem_write = 1'b1;
    dc_mem_addr  = 28'h10;
    dc_mem_wdata = {4{32'hD0D0_D0D0}};
    ic_mem_read  = 1'b1;
    ic_mem_addr  = 28'h20;
    tick();
    chk("tie_d_write", mem_write, 1);
    chk("tie_d_read", mem_read, 0);
    chk("tie_d_addr", mem_addr, 28'h10);
    chk("tie_d_wdata", mem_wdata, {4{32'hD0D0_D0D0}});
    tick();
    mem_ready = 1'b1;
    #1;
    chk("tie_dc_ready", dc_mem_ready, 1);
    chk("tie_ic_not_ready", ic_mem_ready, 0);
    tick();
    mem_ready    = 1'b0;
    dc_mem_write = 1'b0;
    chk("tie_bubble_read", mem_read, 0);
    chk("tie_bubble_busy", arb_busy, 0);
    tick();
    chk("tie_i_read", mem_read, 1);
    chk("tie_i_addr", mem_addr, 28'h20);
    mem_rdata = 128'h4242;
    mem_ready = 1'b1;
    #1;
    chk("tie_ic_ready", ic_mem_ready, 1);
    chk("tie_ic_rdata", ic_mem_rdata, 128'h4242);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    drop_reqs();

    // Saturation: both caches request continuously, grants strictly alternate
    reset_dut();
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h40;
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h30;
    for (int t = 0; t < 6; t++) begin
      exp_d = ((t % 2) == 0);
      tick();
      chk("sat_grant_addr", mem_addr, exp_d ? 28'h30 : 28'h40);
      tick();
      mem_rdata = 128'(t + 1);
      mem_ready = 1'b1;
      #1;
      chk("sat_exclusive", ic_mem_ready & dc_mem_ready, 0);
      chk("sat_dc_ready", dc_mem_ready, exp_d);
      chk("sat_ic_ready", ic_mem_ready, !exp_d);
      tick();
      mem_ready = 1'b0;
    end
    drop_reqs();
    tick();

    // Stability: request inputs change while granted, memory outputs must not
    dc_mem_write = 1'b1;
    dc_mem_addr  = 28'h50;
    dc_mem_wdata = {4{32'h0000_0A0A}};
    tick();
    dc_mem_addr  = 28'h51;
    dc_mem_wdata = {4{32'hBBBB_0000}};
    tick();
    chk("stab_addr_1", mem_addr, 28'h50);
    chk("stab_wdata_1", mem_wdata, {4{32'h0000_0A0A}});
    tick();
    chk("stab_addr_2", mem_addr, 28'h50);
    chk("stab_wdata_2", mem_wdata, {4{32'h0000_0A0A}});
    mem_ready = 1'b1;
    #1;
    chk("stab_dc_ready", dc_mem_ready, 1);
    tick();
    mem_ready = 1'b0;
    drop_reqs();
    chk("stab_wdata_clear", mem_wdata, 0);

    // Spurious mem_ready while idle produces no ready pulse
    tick();
    mem_ready = 1'b1;
    mem_rdata = 128'h99;
    #1;
    chk("spur_ic_ready", ic_mem_ready, 0);
    chk("spur_dc_ready", dc_mem_ready, 0);
    chk("spur_ic_rdata", ic_mem_rdata, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk("spur_busy", arb_busy, 0);

    // Reset in the middle of an I-cache grant, then re-grant of the held request
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h60;
    tick();
    chk("midrst_granted", mem_read, 1);
    proc_reset_n = 1'b0;
    mem_ready    = 1'b1;
    #1;
    chk("midrst_read_clear", mem_read, 0);
    chk("midrst_addr_clear", mem_addr, 0);
    chk("midrst_no_ready", ic_mem_ready, 0);
    chk("midrst_busy", arb_busy, 0);
    mem_ready = 1'b0;
    tick();
    proc_reset_n = 1'b1;
    tick();
    chk("midrst_regrant_read", mem_read, 1);
    chk("midrst_regrant_addr", mem_addr, 28'h60);
    mem_rdata = 128'hABCD;
    mem_ready = 1'b1;
    #1;
    chk("midrst_ic_ready", ic_mem_ready, 1);
    chk("midrst_ic_rdata", ic_mem_rdata, 128'hABCD);
    tick();
    mem_ready = 1'b0;
    drop_reqs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
